// File: rtl/fixed_to_float.sv
// Iterative signed Q1.31 to IEEE-754 single converter for the cosine accelerator back end.
// Normalises one bit per enabled cycle, then rounds to nearest-even and pulses done.
module fixed_to_float #(
  parameter int FRAC_BITS = 31
) (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  localparam int MSB = FRAC_BITS - 1;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           sign_q;
  logic           special_q;
  logic [MSB:0]   mag_q;
  logic [4:0]     k_q;
  logic [31:0]    result_q;
  logic           done_q;

  logic [MSB:0]   abs_mag;
  logic [7:0]     exp_base;
  logic [22:0]    mant;
  logic           guard_bit;
  logic           sticky_bit;
  logic           round_up;
  logic [23:0]    mant_sum;
  logic [7:0]     exp_out;
  logic [31:0]    packed_out;

  // Two's-complement magnitude kept to 31 bits; -1.0 wraps to zero and is caught as special.
  assign abs_mag = dataa[31] ? (~dataa[MSB:0] + 1'b1) : dataa[MSB:0];

  assign exp_base   = 8'd126 - {3'b000, k_q};
  assign mant       = mag_q[MSB-1 -: 23];
  assign guard_bit  = mag_q[MSB-24];
  assign sticky_bit = |mag_q[MSB-25:0];
  assign round_up   = guard_bit & (sticky_bit | mant[0]);
  assign mant_sum   = {1'b0, mant} + {23'd0, round_up};
  assign exp_out    = exp_base + {7'd0, mant_sum[23]};

  always_comb begin
    packed_out = {sign_q, exp_out, mant_sum[22:0]};
    if (special_q)
      packed_out = sign_q ? 32'hBF80_0000 : 32'h0000_0000;
  end

  // Specials still pass through NORM for one cycle so every conversion takes at least two edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = NORM;
      NORM:    if (special_q || mag_q[MSB]) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      mag_q     <= '0;
      k_q       <= 5'd0;
      result_q  <= 32'd0;
      done_q    <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      done_q  <= (state_q == ROUND);
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q    <= dataa[31];
            special_q <= (dataa[MSB:0] == '0);
            mag_q     <= abs_mag;
            k_q       <= 5'd0;
          end
        end
        NORM: begin
          if (!special_q && !mag_q[MSB]) begin
            mag_q <= {mag_q[MSB-1:0], 1'b0};
            k_q   <= k_q + 5'd1;
          end
        end
        ROUND:   result_q <= packed_out;
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q == NORM) || (state_q == ROUND);

endmodule

// File: tb/tb_fixed_to_float.sv
// Self-checking bench for fixed_to_float: directed spec vectors plus random operands
// compared against an arithmetic reference model of Q1.31 to single conversion.
module tb_fixed_to_float;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  fixed_to_float #(.FRAC_BITS(31)) dut (
    .clock  (clock),
    .aclr_n (aclr_n),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  function automatic int lead_pos(input logic [31:0] mag);
    int p = 0;
    for (int i = 0; i < 31; i++)
      if (mag[i]) p = i;
    return p;
  endfunction

  // Exact magnitude scaled so the leading one lands on bit 23, then nearest-even rounding.
  function automatic logic [31:0] ref_float(input logic [31:0] d);
    logic [31:0] mag;
    logic        s;
    int          p, e, sh;
    longint      q, rem, half;
    if (d[30:0] == 31'd0) return d[31] ? 32'hBF80_0000 : 32'h0000_0000;
    s   = d[31];
    mag = s ? (32'd0 - d) : d;
    p   = lead_pos(mag);
    e   = 96 + p;
    if (p > 23) begin
      sh   = p - 23;
      q    = longint'(mag) >> sh;
      rem  = longint'(mag) - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end else begin
      q = longint'(mag) << (23 - p);
    end
    return {s, 8'(e), 23'(q)};
  endfunction

  function automatic int ref_latency(input logic [31:0] d);
    logic [31:0] mag;
    if (d[30:0] == 31'd0) return 2;
    mag = d[31] ? (32'd0 - d) : d;
    return 32 - lead_pos(mag);
  endfunction

  task automatic run_conv(input logic [31:0] d, input int stall_at, input int stall_len,
                          input bit poke, output logic [31:0] res, output int lat);
    int edges;
    bit seen;
    bit busy_ok;
    int stall_left;
    stall_left = stall_len;
    start = 1'b1;
    dataa = d;
    @(posedge clock); #1;
    start   = 1'b0;
    busy_ok = (busy === 1'b1) && (done === 1'b0);
    edges   = 0;
    seen    = 1'b0;
    res     = 32'hxxxx_xxxx;
    lat     = -1;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (poke) begin
        start = 1'b1;
        dataa = $urandom;
      end
      if (edges == stall_at && stall_left > 0) begin
        clk_en = 1'b0;
        repeat (stall_left) begin
          @(posedge clock); #1;
          if (done !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
        end
        clk_en     = 1'b1;
        stall_left = 0;
      end
      @(posedge clock); #1;
      edges++;
      if (done === 1'b1) begin
        seen = 1'b1;
        res  = result;
        lat  = edges;
        if (busy !== 1'b0) busy_ok = 1'b0;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL timeout data=%h got no done, required done within 200 cycles", d);
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("[TB] FAIL busy_done data=%h busy/done overlap or gap, required busy exactly until done", d);
    end
    if (seen) begin
      @(posedge clock); #1;
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL done_pulse data=%h got done=%b, required 0", d, done);
      end
    end
  endtask

  task automatic test_reset();
    aclr_n = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (result !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_result got %h, required 00000000", result);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_done got %b, required 0", done);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_busy got %b, required 0", busy);
    end
    @(negedge clock);
    aclr_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ins  [9] = '{32'h6EC1BCCD, 32'h40000000, 32'hC0000000, 32'h00000001,
                              32'h40000040, 32'h400000C0, 32'h7FFFFFC0, 32'h00000000, 32'h80000000};
    logic [31:0] outs [9] = '{32'h3F5D837A, 32'h3F000000, 32'hBF000000, 32'h30000000,
                              32'h3F000000, 32'h3F000002, 32'h3F800000, 32'h00000000, 32'hBF800000};
    int          lats [9] = '{2, 2, 2, 32, 2, 2, 2, 2, 2};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      run_conv(ins[i], -1, 0, 1'b0, res, lat);
      total++;
      if (res !== outs[i]) begin
        bad++;
        $display("[TB] FAIL directed_result data=%h got %h, required %h", ins[i], res, outs[i]);
      end
      total++;
      if (lat != lats[i]) begin
        bad++;
        $display("[TB] FAIL directed_latency data=%h got %0d, required %0d", ins[i], lat, lats[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, res;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = 32'd0 - d;
      run_conv(d, -1, 0, 1'b0, res, lat);
      total++;
      if (res !== ref_float(d)) begin
        bad++;
        $display("[TB] FAIL random_result data=%h got %h, required %h", d, res, ref_float(d));
      end
      total++;
      if (lat != ref_latency(d)) begin
        bad++;
        $display("[TB] FAIL random_latency data=%h got %0d, required %0d", d, lat, ref_latency(d));
      end
    end
  endtask

  task automatic test_clk_en();
    logic [31:0] res;
    int          lat;
    bit          seen;
    run_conv(32'h00000001, 10, 5, 1'b0, res, lat);
    total++;
    if (res !== 32'h30000000) begin
      bad++;
      $display("[TB] FAIL stall_result got %h, required 30000000", res);
    end
    total++;
    if (lat != 32) begin
      bad++;
      $display("[TB] FAIL stall_latency got %0d, required 32", lat);
    end
    // done must freeze high while clk_en is low after completion
    start = 1'b1;
    dataa = 32'h40000000;
    @(posedge clock); #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL hold_timeout got no done, required done within 50 cycles");
    end
    clk_en = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (done !== 1'b1 || result !== 32'h3F000000) begin
      bad++;
      $display("[TB] FAIL hold_done got done=%b result=%h, required done=1 result=3F000000", done, result);
    end
    clk_en = 1'b1;
    @(posedge clock); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_release got done=%b, required 0", done);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] res;
    int          lat;
    run_conv(32'h6EC1BCCD, -1, 0, 1'b1, res, lat);
    total++;
    if (res !== 32'h3F5D837A) begin
      bad++;
      $display("[TB] FAIL ignore_short got %h, required 3F5D837A", res);
    end
    run_conv(32'hFFFFF123, -1, 0, 1'b1, res, lat);
    total++;
    if (res !== ref_float(32'hFFFFF123) || lat != ref_latency(32'hFFFFF123)) begin
      bad++;
      $display("[TB] FAIL ignore_long got %h lat %0d, required %h lat %0d",
               res, lat, ref_float(32'hFFFFF123), ref_latency(32'hFFFFF123));
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int          lat;
    start = 1'b1;
    dataa = 32'h00000001;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    aclr_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("[TB] FAIL async_reset got busy=%b done=%b result=%h, required 0 0 00000000",
               busy, done, result);
    end
    #2;
    aclr_n = 1'b1;
    run_conv(32'h40000000, -1, 0, 1'b0, res, lat);
    total++;
    if (res !== 32'h3F000000 || lat != 2) begin
      bad++;
      $display("[TB] FAIL after_reset got %h lat %0d, required 3F000000 lat 2", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, res;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      d = $urandom >> $urandom_range(0, 8);
      run_conv(d, -1, 0, 1'b0, res, lat);
      total++;
      if (res !== ref_float(d) || lat != ref_latency(d)) begin
        bad++;
        $display("[TB] FAIL b2b data=%h got %h lat %0d, required %h lat %0d",
                 d, res, lat, ref_float(d), ref_latency(d));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_clk_en();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
